// File: rtl/vtim_pkg.sv
// Shared encodings and per-mode line thresholds for the vertical timing generator.
package vtim_pkg;

    typedef enum logic [1:0] {
        MODE_MONO = 2'd0,
        MODE_PAL  = 2'd1,
        MODE_NTSC = 2'd2,
        MODE_CUST = 2'd3
    } vtim_mode_e;

    typedef struct packed {
        logic [15:0] total;
        logic [15:0] vde_on;
        logic [15:0] vde_off;
        logic [15:0] vbl_on;
        logic [15:0] vbl_off;
    } vtim_thr_t;

    localparam int VS_LEN_DEF = 3;

    localparam vtim_thr_t THR_MONO = '{total: 16'd501, vde_on: 16'd35, vde_off: 16'd435,
                                       vbl_on: 16'd0, vbl_off: 16'd0};
    localparam vtim_thr_t THR_PAL  = '{total: 16'd313, vde_on: 16'd62, vde_off: 16'd262,
                                       vbl_on: 16'd24, vbl_off: 16'd307};
    localparam vtim_thr_t THR_NTSC = '{total: 16'd263, vde_on: 16'd33, vde_off: 16'd233,
                                       vbl_on: 16'd15, vbl_off: 16'd257};

    // Custom mode has no fixed table; the caller substitutes the shadowed inputs.
    function automatic vtim_thr_t mode_thr(input logic [1:0] m);
        vtim_thr_t t;
        t = '0;
        case (m)
            MODE_MONO: t = THR_MONO;
            MODE_PAL:  t = THR_PAL;
            MODE_NTSC: t = THR_NTSC;
            default:   t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/vtim_window.sv
// Line-window flag: set when the counter hits `on`, cleared at `off` (clear wins).
module vtim_window
    import vtim_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             force_clr,
    input  logic             stb,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] on,
    input  logic [CNT_W-1:0] off,
    output logic             flag
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= 1'b0;
        end else if (clr || force_clr) begin
            flag <= 1'b0;
        end else if (stb) begin
            if (cnt == off) begin
                flag <= 1'b0;
            end else if (cnt == on) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vtimgen.sv
// Vertical timing generator: scanline counter, vde/vblank windows, vsync and
// frame strobe, with per-frame shadowing of the mode and custom thresholds.
module vtimgen
    import vtim_pkg::*;
#(
    parameter int         CNT_W      = 9,
    parameter int         VS_LEN     = VS_LEN_DEF,
    parameter logic [1:0] RESET_MODE = 2'd1
) (
    input  logic             clk,
    input  logic             porb,
    input  logic             hs_stb,
    input  logic             ivsync,
    input  logic             ext_sync,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cust_total,
    input  logic [CNT_W-1:0] cust_vde_on,
    input  logic [CNT_W-1:0] cust_vde_off,
    input  logic [CNT_W-1:0] cust_vbl_on,
    input  logic [CNT_W-1:0] cust_vbl_off,
    output logic             vde,
    output logic             vblank,
    output logic             vsync_o,
    output logic [CNT_W-1:0] line,
    output logic [CNT_W-1:0] de_line,
    output logic             frame_stb
);

    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cust_total_q, cust_vde_on_q, cust_vde_off_q, cust_vbl_on_q, cust_vbl_off_q;
    vtim_thr_t        fixed_thr;
    logic [CNT_W-1:0] total_sel, total_eff, vde_on, vde_off, vbl_on, vbl_off;
    logic [CNT_W-1:0] line_nxt;
    logic             sync_clr, vde_set, is_mono;

    assign fixed_thr = mode_thr(mode_q);
    assign is_mono   = (mode_q == MODE_MONO);
    assign sync_clr  = ext_sync && ivsync;

    always_comb begin
        total_sel = CNT_W'(fixed_thr.total);
        vde_on    = CNT_W'(fixed_thr.vde_on);
        vde_off   = CNT_W'(fixed_thr.vde_off);
        vbl_on    = CNT_W'(fixed_thr.vbl_on);
        vbl_off   = CNT_W'(fixed_thr.vbl_off);
        if (mode_q == MODE_CUST) begin
            total_sel = cust_total_q;
            vde_on    = cust_vde_on_q;
            vde_off   = cust_vde_off_q;
            vbl_on    = cust_vbl_on_q;
            vbl_off   = cust_vbl_off_q;
        end
    end

    // A one-line frame would never leave line 0, so the shortest frame is two lines.
    assign total_eff = (total_sel < CNT_W'(2)) ? CNT_W'(2) : total_sel;

    // >= rather than == so a counter left beyond total (ext_sync dropped) still wraps.
    always_comb begin
        line_nxt = line;
        if (sync_clr) begin
            line_nxt = '0;
        end else if (hs_stb) begin
            if (ext_sync) begin
                if (line != '1) line_nxt = line + CNT_W'(1);
            end else if (line >= total_eff - CNT_W'(1)) begin
                line_nxt = '0;
            end else begin
                line_nxt = line + CNT_W'(1);
            end
        end
    end

    assign vde_set = hs_stb && (line == vde_on) && (line != vde_off);
    assign vsync_o = ext_sync ? ivsync : (line < CNT_W'(VS_LEN));

    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            line           <= '0;
            de_line        <= '0;
            frame_stb      <= 1'b0;
            mode_q         <= RESET_MODE;
            cust_total_q   <= '0;
            cust_vde_on_q  <= '0;
            cust_vde_off_q <= '0;
            cust_vbl_on_q  <= '0;
            cust_vbl_off_q <= '0;
        end else begin
            line      <= line_nxt;
            frame_stb <= (line != '0) && (line_nxt == '0);
            if (sync_clr) begin
                de_line <= '0;
            end else if (vde_set) begin
                de_line <= '0;
            end else if (hs_stb && vde) begin
                de_line <= de_line + CNT_W'(1);
            end
            if (frame_stb) begin
                mode_q         <= mode;
                cust_total_q   <= cust_total;
                cust_vde_on_q  <= cust_vde_on;
                cust_vde_off_q <= cust_vde_off;
                cust_vbl_on_q  <= cust_vbl_on;
                cust_vbl_off_q <= cust_vbl_off;
            end
        end
    end

    vtim_window #(.CNT_W(CNT_W)) u_vde_win (
        .clk       (clk),
        .rst_n     (porb),
        .clr       (sync_clr),
        .force_clr (1'b0),
        .stb       (hs_stb),
        .cnt       (line),
        .on        (vde_on),
        .off       (vde_off),
        .flag      (vde)
    );

    vtim_window #(.CNT_W(CNT_W)) u_vbl_win (
        .clk       (clk),
        .rst_n     (porb),
        .clr       (sync_clr),
        .force_clr (is_mono),
        .stb       (hs_stb),
        .cnt       (line),
        .on        (vbl_on),
        .off       (vbl_off),
        .flag      (vblank)
    );

endmodule

// File: tb/tb_vtimgen.sv
// Directed bench for vtimgen: per-cycle comparison against a line-level model
// plus literal expectations at window edges, wraps and saturation.
module tb_vtimgen;

    logic       clk = 1'b0;
    logic       porb = 1'b0;
    logic       hs_stb = 1'b0;
    logic       ivsync = 1'b0;
    logic       ext_sync = 1'b0;
    logic [1:0] mode = 2'd1;
    logic [8:0] cust_total = '0, cust_vde_on = '0, cust_vde_off = '0;
    logic [8:0] cust_vbl_on = '0, cust_vbl_off = '0;
    logic       vde, vblank, vsync_o, frame_stb;
    logic [8:0] line, de_line;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int n_vde, n_vbl, n_fs;

    vtimgen dut (
        .clk          (clk),
        .porb         (porb),
        .hs_stb       (hs_stb),
        .ivsync       (ivsync),
        .ext_sync     (ext_sync),
        .mode         (mode),
        .cust_total   (cust_total),
        .cust_vde_on  (cust_vde_on),
        .cust_vde_off (cust_vde_off),
        .cust_vbl_on  (cust_vbl_on),
        .cust_vbl_off (cust_vbl_off),
        .vde          (vde),
        .vblank       (vblank),
        .vsync_o      (vsync_o),
        .line         (line),
        .de_line      (de_line),
        .frame_stb    (frame_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level model: one frame table per mode, windows as set/clear events.
    int tbl [3][5] = '{'{501, 35, 435, 0, 0}, '{313, 62, 262, 24, 307}, '{263, 33, 233, 15, 257}};
    int m_line = 0, m_de = 0, m_mode = 1;
    int m_cust [5] = '{0, 0, 0, 0, 0};
    bit m_vde = 0, m_vbl = 0, m_fs = 0;

    always @(posedge clk or negedge porb) begin
        int prev, tot, von, voff, bon, boff;
        bit fs_old;
        if (!porb) begin
            m_line = 0; m_de = 0; m_vde = 0; m_vbl = 0; m_fs = 0; m_mode = 1;
            m_cust = '{0, 0, 0, 0, 0};
        end else begin
            prev = m_line;
            fs_old = m_fs;
            if (m_mode == 3) begin
                tot = m_cust[0]; von = m_cust[1]; voff = m_cust[2]; bon = m_cust[3]; boff = m_cust[4];
                if (tot < 2) tot = 2;
            end else begin
                tot = tbl[m_mode][0]; von = tbl[m_mode][1]; voff = tbl[m_mode][2];
                bon = tbl[m_mode][3]; boff = tbl[m_mode][4];
            end
            if (ext_sync && ivsync) begin
                m_line = 0; m_de = 0; m_vde = 0; m_vbl = 0;
            end else if (hs_stb) begin
                if (prev == von && von != voff) m_de = 0;
                else if (m_vde) m_de = (m_de + 1) % 512;
                if (prev == voff) m_vde = 0;
                else if (prev == von) m_vde = 1;
                if (prev == boff) m_vbl = 0;
                else if (prev == bon) m_vbl = 1;
                if (ext_sync) m_line = (prev == 511) ? 511 : prev + 1;
                else m_line = (prev >= tot - 1) ? 0 : prev + 1;
            end
            if (m_mode == 0) m_vbl = 0;
            m_fs = (prev != 0) && (m_line == 0);
            if (fs_old) begin
                m_mode = int'(mode);
                m_cust = '{int'(cust_total), int'(cust_vde_on), int'(cust_vde_off),
                           int'(cust_vbl_on), int'(cust_vbl_off)};
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("line", int'(line), m_line);
            chk("de_line", int'(de_line), m_de);
            chk("vde", int'(vde), int'(m_vde));
            chk("vblank", int'(vblank), int'(m_vbl));
            chk("frame_stb", int'(frame_stb), int'(m_fs));
            chk("vsync_o", int'(vsync_o), ext_sync ? int'(ivsync) : int'(m_line < 3));
        end
    end

    task automatic strobe();
        @(posedge clk); #1 hs_stb = 1'b1;
        @(posedge clk); #1 hs_stb = 1'b0;
        @(negedge clk); #1;
        n_vde += int'(vde); n_vbl += int'(vblank); n_fs += int'(frame_stb);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) strobe();
    endtask

    task automatic vsync_pulse();
        @(posedge clk); #1 ivsync = 1'b1;
        @(posedge clk); #1 ivsync = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic relatch();
        ext_sync = 1'b1;
        strobe();
        vsync_pulse();
        ext_sync = 1'b0;
    endtask

    task automatic clr_counts();
        n_vde = 0; n_vbl = 0; n_fs = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_counts();
        repeat (3) @(negedge clk);
        chk("rst_line", int'(line), 0);
        chk("rst_de_line", int'(de_line), 0);
        chk("rst_vde", int'(vde), 0);
        chk("rst_vblank", int'(vblank), 0);
        chk("rst_frame_stb", int'(frame_stb), 0);
        chk("rst_vsync_free", int'(vsync_o), 1);
        cmp_en = 1'b1;
        @(posedge clk); #1 porb = 1'b1;

        // PAL free-run, two frames
        for (int k = 0; k < 626; k++) begin
            strobe();
            if (k == 23)  chk("pal_vbl_pre", int'(vblank), 0);
            if (k == 24)  chk("pal_vbl_on", int'(vblank), 1);
            if (k == 61)  chk("pal_vde_pre", int'(vde), 0);
            if (k == 62)  begin chk("pal_vde_on", int'(vde), 1); chk("pal_de0", int'(de_line), 0); end
            if (k == 261) begin chk("pal_vde_last", int'(vde), 1); chk("pal_de199", int'(de_line), 199); end
            if (k == 262) chk("pal_vde_off", int'(vde), 0);
            if (k == 306) chk("pal_vbl_last", int'(vblank), 1);
            if (k == 307) chk("pal_vbl_off", int'(vblank), 0);
            if (k == 311) chk("pal_line312", int'(line), 312);
            if (k == 312) chk("pal_wrap", int'(line), 0);
        end
        chk("pal_vde_lines", n_vde, 400);
        chk("pal_vbl_lines", n_vbl, 566);
        chk("pal_frames", n_fs, 2);

        // mid-frame switch to NTSC: rest of this frame stays PAL
        strobes(100);
        mode = 2'd2;
        for (int k = 100; k < 313; k++) begin
            strobe();
            if (k == 233) chk("pal_kept_vde", int'(vde), 1);
            if (k == 312) chk("pal_kept_wrap", int'(line), 0);
        end
        clr_counts();
        strobes(263);
        chk("ntsc_vde_lines", n_vde, 200);
        chk("ntsc_vbl_lines", n_vbl, 242);
        chk("ntsc_wrap", int'(line), 0);
        chk("ntsc_frames", n_fs, 1);

        // NTSC following external vsync
        ext_sync = 1'b1;
        vsync_pulse();
        for (int f = 0; f < 2; f++) begin
            clr_counts();
            strobes(263);
            chk("sync_line263", int'(line), 263);
            chk("sync_vde_lines", n_vde, 200);
            chk("sync_vbl_lines", n_vbl, 242);
            vsync_pulse();
            chk("sync_clr_line", int'(line), 0);
            chk("sync_frame_stb", int'(frame_stb), 1);
        end
        strobes(5);
        @(posedge clk); #1 begin ivsync = 1'b1; hs_stb = 1'b1; end
        @(posedge clk); #1 begin ivsync = 1'b0; hs_stb = 1'b0; end
        @(negedge clk); #1;
        chk("clr_beats_stb", int'(line), 0);

        // mono free-run
        mode = 2'd0;
        strobe();
        vsync_pulse();
        ext_sync = 1'b0;
        clr_counts();
        strobes(501);
        chk("mono_vde_lines", n_vde, 400);
        chk("mono_vbl_lines", n_vbl, 0);
        chk("mono_frames", n_fs, 1);
        chk("mono_wrap", int'(line), 0);

        // custom: on == off never asserts
        mode = 2'd3;
        cust_total = 9'd10; cust_vde_on = 9'd9; cust_vde_off = 9'd9;
        cust_vbl_on = 9'd3; cust_vbl_off = 9'd5;
        relatch();
        clr_counts();
        strobes(30);
        chk("cust_eq_vde", n_vde, 0);
        chk("cust_vbl_lines", n_vbl, 6);
        chk("cust_wrap", int'(line), 0);

        // custom: window spanning the wrap
        cust_vde_on = 9'd8; cust_vde_off = 9'd2;
        relatch();
        clr_counts();
        for (int k = 0; k < 30; k++) begin
            strobe();
            if (k == 8)  begin chk("span_set", int'(vde), 1); chk("span_de0", int'(de_line), 0); end
            if (k == 11) begin chk("span_thru", int'(vde), 1); chk("span_de3", int'(de_line), 3); end
            if (k == 12) chk("span_clr", int'(vde), 0);
        end
        chk("span_vde_lines", n_vde, 10);

        // custom total below two behaves as two
        cust_total = 9'd0;
        relatch();
        strobes(3);
        chk("tot_min_line1", int'(line), 1);
        strobe();
        chk("tot_min_wrap", int'(line), 0);

        // sync mode without vsync saturates, then async reset mid-frame
        ext_sync = 1'b1;
        strobes(600);
        chk("sat_line", int'(line), 511);
        chk("sat_vde", int'(vde), 1);
        @(posedge clk); #2 porb = 1'b0;
        #1;
        chk("arst_line", int'(line), 0);
        chk("arst_de_line", int'(de_line), 0);
        chk("arst_vde", int'(vde), 0);
        chk("arst_vblank", int'(vblank), 0);
        chk("arst_frame_stb", int'(frame_stb), 0);
        #10 porb = 1'b1;
        strobe();
        chk("post_rst_line", int'(line), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
